// File: rtl/servant_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : servant_irq_ctrl
// Purpose  : Wishbone-slave external interrupt controller for the servant SoC.
//            Latches rising edges of up to 31 peripheral interrupt sources
//            into a pending register, masks them with a software enable
//            register and hands the lowest-numbered eligible source to the
//            SERV core one at a time through a claim/complete handshake.
// Ports    : wb_clk    - system clock, rising edge
//            wb_rst_n  - synchronous active-low reset
//            i_src     - interrupt sources (synchronous), rising edge requests
//            i_wb_adr  - word address: 0 PENDING, 1 ENABLE, 2 CLAIM, 3 COMPLETE
//            i_wb_dat  - write data
//            i_wb_we   - write enable
//            i_wb_cyc  - bus cycle request, held until ack
//            o_wb_rdt  - read data, valid with o_wb_ack
//            o_wb_ack  - single-cycle acknowledge
//            o_irq     - registered interrupt request to the core ext_irq
// Revision : 1.0 - initial release
// ============================================================================
module servant_irq_ctrl #(
  parameter int NUM_SRC = 8
) (
  input  logic               wb_clk,
  input  logic               wb_rst_n,
  input  logic [NUM_SRC-1:0] i_src,
  input  logic [1:0]         i_wb_adr,
  input  logic [31:0]        i_wb_dat,
  input  logic               i_wb_we,
  input  logic               i_wb_cyc,
  output logic [31:0]        o_wb_rdt,
  output logic               o_wb_ack,
  output logic               o_irq
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam logic [1:0] C_ADR_PENDING  = 2'd0;
  localparam logic [1:0] C_ADR_ENABLE   = 2'd1;
  localparam logic [1:0] C_ADR_CLAIM    = 2'd2;
  localparam logic [1:0] C_ADR_COMPLETE = 2'd3;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [4:0]         active_id_q, active_id_d;
  logic               ack_q, ack_d;
  logic [31:0]        rdt_q, rdt_d;
  logic               irq_q, irq_d;

  logic [NUM_SRC-1:0] w_edge;
  logic [NUM_SRC-1:0] w_elig;
  logic [NUM_SRC-1:0] w_clr;
  logic               w_any;
  logic [4:0]         w_sel_id;
  logic               w_fire;
  logic               w_claim;
  logic               w_unused;

  // Only the low bits of the write data are architecturally meaningful.
  assign w_unused = ^i_wb_dat;

  always_comb begin
    w_edge = i_src & ~src_q;
    w_elig = pending_q & enable_q;
    w_any  = |w_elig;

    // Descending scan so the lowest eligible index is the one that sticks.
    w_sel_id = 5'd0;
    for (int n = NUM_SRC - 1; n >= 0; n--) begin
      if (w_elig[n]) w_sel_id = 5'(n + 1);
    end

    // Side effects happen only on the edge that raises ack: once per cycle.
    w_fire  = i_wb_cyc & ~ack_q;
    w_claim = w_fire & ~i_wb_we & (i_wb_adr == C_ADR_CLAIM) &
              (state_q == ST_IDLE) & w_any;

    for (int n = 0; n < NUM_SRC; n++) begin
      w_clr[n] = w_claim && (w_sel_id == 5'(n + 1));
    end

    // A new edge on the bit being claimed wins over the clear.
    pending_d = (pending_q & ~w_clr) | w_edge;

    enable_d = enable_q;
    if (w_fire && i_wb_we && (i_wb_adr == C_ADR_ENABLE)) begin
      enable_d = i_wb_dat[NUM_SRC-1:0];
    end

    state_d     = state_q;
    active_id_d = active_id_q;
    if (w_claim) begin
      state_d     = ST_BUSY;
      active_id_d = w_sel_id;
    end else if (w_fire && i_wb_we && (i_wb_adr == C_ADR_COMPLETE) &&
                 (state_q == ST_BUSY) && (i_wb_dat[4:0] == active_id_q)) begin
      state_d = ST_IDLE;
    end

    rdt_d = 32'h0;
    if (w_fire && !i_wb_we) begin
      case (i_wb_adr)
        C_ADR_PENDING: rdt_d[NUM_SRC-1:0] = pending_q;
        C_ADR_ENABLE:  rdt_d[NUM_SRC-1:0] = enable_q;
        C_ADR_CLAIM:   rdt_d[4:0] = (state_q == ST_IDLE) ? w_sel_id : 5'd0;
        default:       rdt_d = 32'h0;
      endcase
    end

    ack_d = i_wb_cyc & ~ack_q;

    // Based on the current state so that a COMPLETE re-asserts one cycle
    // after its ack, while a claim drops the request on its own ack edge.
    irq_d = (state_q == ST_IDLE) & w_any & ~w_claim;
  end

  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      state_q     <= ST_IDLE;
      src_q       <= '0;
      pending_q   <= '0;
      enable_q    <= '0;
      active_id_q <= 5'd0;
      ack_q       <= 1'b0;
      rdt_q       <= 32'h0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= i_src;
      pending_q   <= pending_d;
      enable_q    <= enable_d;
      active_id_q <= active_id_d;
      ack_q       <= ack_d;
      rdt_q       <= rdt_d;
      irq_q       <= irq_d;
    end
  end

  assign o_wb_rdt = rdt_q;
  assign o_wb_ack = ack_q;
  assign o_irq    = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_servant_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_servant_irq_ctrl
// Purpose  : Directed testbench for servant_irq_ctrl. Bus transactions push
//            their expected read data into a queue; an independent monitor
//            pops and compares on every acknowledge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_servant_irq_ctrl;

  localparam int NUM_SRC = 8;

  logic               clk;
  logic               rst_n;
  logic [NUM_SRC-1:0] src;
  logic [1:0]         adr;
  logic [31:0]        dat;
  logic               we;
  logic               cyc;
  logic [31:0]        rdt;
  logic               ack;
  logic               irq;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [31:0] exp_q[$];
  bit          chk_q[$];
  string       name_q[$];

  servant_irq_ctrl #(.NUM_SRC(NUM_SRC)) dut (
    .wb_clk   (clk),
    .wb_rst_n (rst_n),
    .i_src    (src),
    .i_wb_adr (adr),
    .i_wb_dat (dat),
    .i_wb_we  (we),
    .i_wb_cyc (cyc),
    .o_wb_rdt (rdt),
    .o_wb_ack (ack),
    .o_irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every ack consumes one scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && ack) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_ack: ack with empty scoreboard, rdt=0x%08h", rdt);
      end else begin
        logic [31:0] e;
        bit          c;
        string       nm;
        e  = exp_q.pop_front();
        c  = chk_q.pop_front();
        nm = name_q.pop_front();
        if (c) begin
          total_cnt++;
          if (rdt === e) pass_cnt++;
          else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, rdt, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic act, input logic expv);
    total_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got %0b expected %0b", nm, act, expv);
  endtask

  // One Wishbone transaction; called just after a clock edge.
  task automatic bus(input bit wr, input logic [1:0] a, input logic [31:0] d,
                     input logic [31:0] expv, input bit do_chk, input string nm);
    bit got;
    exp_q.push_back(expv);
    chk_q.push_back(do_chk);
    name_q.push_back(nm);
    cyc = 1'b1;
    we  = wr;
    adr = a;
    dat = d;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      step();
      if (ack) got = 1'b1;
    end
    cyc = 1'b0;
    we  = 1'b0;
    dat = 32'h0;
    if (!got) begin
      total_cnt++;
      $display("FAIL %s_timeout: no ack within 8 cycles, expected ack=1", nm);
      void'(exp_q.pop_back());
      void'(chk_q.pop_back());
      void'(name_q.pop_back());
    end
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] expv, input string nm);
    bus(1'b0, a, 32'h0, expv, 1'b1, nm);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus(1'b1, a, d, 32'h0, 1'b0, "write");
  endtask

  task automatic pulse(input logic [NUM_SRC-1:0] m);
    src = m;
    step();
    src = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    src   = '0;
    adr   = 2'd0;
    dat   = 32'h0;
    we    = 1'b0;
    cyc   = 1'b0;

    // Reset with toggling sources
    #1;
    src = 8'hFF; step();
    src = 8'h55; step();
    src = 8'h00; step();
    rst_n = 1'b1;
    chk("reset_irq", irq, 1'b0);
    chk("reset_ack", ack, 1'b0);
    rd(2'd0, 32'h0, "reset_pending");
    rd(2'd1, 32'h0, "reset_enable");

    // Single source
    wr(2'd1, 32'h04);
    pulse(8'h04);
    chk("single_irq_after1", irq, 1'b0);
    step();
    chk("single_irq_after2", irq, 1'b1);
    rd(2'd2, 32'd3, "single_claim");
    chk("single_irq_after_claim", irq, 1'b0);
    rd(2'd0, 32'h0, "single_pending");
    wr(2'd3, 32'd3);
    step(); step();
    chk("single_irq_after_complete", irq, 1'b0);

    // Priority
    wr(2'd1, 32'hFF);
    pulse(8'h22);
    step();
    rd(2'd2, 32'd2, "prio_claim_first");
    wr(2'd3, 32'd2);
    chk("prio_irq_at_complete", irq, 1'b0);
    step();
    chk("prio_irq_reassert", irq, 1'b1);
    rd(2'd2, 32'd6, "prio_claim_second");
    wr(2'd3, 32'd6);

    // Masking
    wr(2'd1, 32'h00);
    pulse(8'h01);
    step(); step();
    chk("mask_irq_low", irq, 1'b0);
    rd(2'd0, 32'h01, "mask_pending");
    wr(2'd1, 32'h01);
    chk("mask_irq_at_ack", irq, 1'b0);
    step();
    chk("mask_irq_after_ack", irq, 1'b1);
    rd(2'd2, 32'd1, "mask_claim");
    wr(2'd3, 32'd1);

    // BUSY rules
    wr(2'd1, 32'hFF);
    pulse(8'h02);
    step();
    rd(2'd2, 32'd2, "busy_claim");
    rd(2'd2, 32'd0, "busy_second_claim");
    wr(2'd3, 32'd5);
    rd(2'd2, 32'd0, "busy_after_bad_complete");
    pulse(8'h01);
    step();
    rd(2'd0, 32'h01, "busy_pending");
    chk("busy_irq_low", irq, 1'b0);
    wr(2'd3, 32'd2);
    rd(2'd2, 32'd1, "busy_claim_after_complete");
    wr(2'd3, 32'd1);

    // Edge/clear collision on source 3
    pulse(8'h08);
    step();
    src = 8'h08;
    rd(2'd2, 32'd4, "coll_claim");
    src = 8'h00;
    rd(2'd0, 32'h08, "coll_pending");
    chk("coll_irq_busy", irq, 1'b0);
    wr(2'd3, 32'd4);
    rd(2'd2, 32'd4, "coll_reclaim");
    wr(2'd3, 32'd4);

    // Ignored writes and write-only register read
    wr(2'd0, 32'hFF);
    rd(2'd0, 32'h0, "pending_write_ignored");
    rd(2'd3, 32'h0, "complete_reads_zero");

    step(); step();
    total_cnt++;
    if (exp_q.size() == 0) pass_cnt++;
    else $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
